usb_rx_ctrl: RTL

Receive-side packet controller for the USB low-speed (1.5 Mb/s) PHY path. It sits directly behind `cdr` and consumes its retimed line symbols `q` once per `strobe`. It detects SYNC, performs NRZI decoding and bit unstuffing, assembles bytes LSB first, detects EOP and reports stuff/framing errors. Its outputs form the packet-level receive stream for the USB protocol engine.

---
 rtl/usb_rx_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/usb_rx_ctrl.sv
// Low-speed USB receive controller: SYNC detect, NRZI decode, bit unstuffing,
// LSB-first byte assembly, EOP detection and stuff/framing error reporting.

package types;
  typedef enum logic [1:0] {
    SE0 = 2'b00,
    J   = 2'b01,
    K   = 2'b10
  } d_port_t;
endpackage

module usb_rx_ctrl #(
  parameter int IDLE_STROBES = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  types::d_port_t q,
  input  logic          strobe,
  input  logic          rx_en,
  output logic [7:0]    rx_data,
  output logic          rx_valid,
  output logic          rx_active,
  output logic          rx_error,
  output logic          eop
);

  localparam int JW = $clog2(IDLE_STROBES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_EOP,
    S_ERROR
  } state_t;

  state_t         state, state_nx;
  types::d_port_t prev, prev_nx;
  logic [2:0]     zcnt, zcnt_nx;
  logic [2:0]     bitcnt, bitcnt_nx;
  logic [2:0]     ones, ones_nx;
  logic [JW-1:0]  jcnt, jcnt_nx;
  logic [7:0]     sr, sr_nx;
  logic [7:0]     data_nx;
  logic           valid_nx, active_nx, error_nx, eop_nx;

  logic           is_j, is_k, is_se0, is_jk, bit_d;
  logic [7:0]     shifted;

  always_comb begin
    is_j    = (q == types::J);
    is_k    = (q == types::K);
    is_se0  = (q == types::SE0);
    is_jk   = is_j | is_k;
    bit_d   = (q == prev);
    shifted = {bit_d, sr[7:1]};
  end

  always_comb begin
    state_nx  = state;
    prev_nx   = prev;
    zcnt_nx   = zcnt;
    bitcnt_nx = bitcnt;
    ones_nx   = ones;
    jcnt_nx   = jcnt;
    sr_nx     = sr;
    data_nx   = rx_data;
    active_nx = rx_active;
    valid_nx  = 1'b0;
    error_nx  = 1'b0;
    eop_nx    = 1'b0;

    if (strobe) begin
      if (is_jk) begin
        prev_nx = q;
      end else if (is_se0) begin
        prev_nx = types::J;
      end

      case (state)
        S_IDLE: begin
          if (is_k) begin
            zcnt_nx  = 3'd1;
            state_nx = S_SYNC;
          end
        end
        S_SYNC: begin
          if (is_se0) begin
            state_nx = S_IDLE;
          end else if (is_jk) begin
            if (!bit_d) begin
              if (zcnt != 3'd7) zcnt_nx = zcnt + 3'd1;
            end else if (zcnt >= 3'd3) begin
              // The closing 1 of SYNC already counts toward the stuffing run.
              state_nx  = S_DATA;
              active_nx = 1'b1;
              bitcnt_nx = 3'd0;
              ones_nx   = 3'd1;
            end else begin
              state_nx = S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (is_se0) begin
            state_nx  = S_EOP;
            error_nx  = (bitcnt != 3'd0);
            bitcnt_nx = 3'd0;
          end else if (is_jk) begin
            if (bit_d && ones == 3'd6) begin
              error_nx  = 1'b1;
              active_nx = 1'b0;
              state_nx  = S_ERROR;
              jcnt_nx   = '0;
            end else if (!bit_d && ones == 3'd6) begin
              ones_nx = 3'd0;
            end else begin
              ones_nx = bit_d ? ones + 3'd1 : 3'd0;
              sr_nx   = shifted;
              if (bitcnt == 3'd7) begin
                data_nx   = shifted;
                valid_nx  = 1'b1;
                bitcnt_nx = 3'd0;
              end else begin
                bitcnt_nx = bitcnt + 3'd1;
              end
            end
          end
        end
        S_EOP: begin
          if (is_j) begin
            eop_nx    = 1'b1;
            active_nx = 1'b0;
            state_nx  = S_IDLE;
          end else if (is_k) begin
            error_nx  = 1'b1;
            active_nx = 1'b0;
            state_nx  = S_ERROR;
            jcnt_nx   = '0;
          end
        end
        S_ERROR: begin
          if (is_j) begin
            if (jcnt == JW'(IDLE_STROBES - 1)) begin
              jcnt_nx  = '0;
              state_nx = S_IDLE;
            end else begin
              jcnt_nx = jcnt + JW'(1);
            end
          end else begin
            jcnt_nx = '0;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end

    // Transmitter owns the bus: park in IDLE and stay silent.
    if (!rx_en) begin
      state_nx  = S_IDLE;
      prev_nx   = types::J;
      zcnt_nx   = 3'd0;
      bitcnt_nx = 3'd0;
      ones_nx   = 3'd0;
      jcnt_nx   = '0;
      active_nx = 1'b0;
      valid_nx  = 1'b0;
      error_nx  = 1'b0;
      eop_nx    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      prev      <= types::J;
      zcnt      <= 3'd0;
      bitcnt    <= 3'd0;
      ones      <= 3'd0;
      jcnt      <= '0;
      sr        <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      rx_active <= 1'b0;
      rx_error  <= 1'b0;
      eop       <= 1'b0;
    end else begin
      state     <= state_nx;
      prev      <= prev_nx;
      zcnt      <= zcnt_nx;
      bitcnt    <= bitcnt_nx;
      ones      <= ones_nx;
      jcnt      <= jcnt_nx;
      sr        <= sr_nx;
      rx_data   <= data_nx;
      rx_valid  <= valid_nx;
      rx_active <= active_nx;
      rx_error  <= error_nx;
      eop       <= eop_nx;
    end
  end

endmodule
